prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
Parametrised program sequencer that replaces the fixed PC plus hard-coded done compare in the processor top.
- Adds a req/done start handshake, a configurable start address and halt address, and a stall input.
- Adds jump/branch redirect and a call/return address stack of configurable depth.
- Adds a saturating run-cycle counter for performance measurement.
- Drives prog_ctr into the instruction ROM; control/branch logic drives its redirect inputs.

Parameters:
D, 12, program counter width in bits
START_ADDR, 0, first prog_ctr value of every run
HALT_ADDR, 285, prog_ctr value that ends a run
RAS_DEPTH, 4, return-address-stack entries (>=1)
CW, 16, cycle counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  start request, level sampled
stall  input  1  freeze PC this cycle (RUN only)
jb_en  input  1  taken jump/branch; load target
call  input  1  jump to target and push return address
ret  input  1  pop return address into PC
halt  input  1  force end of run
target  input  D  redirect address for jb_en/call
prog_ctr  output  D  current fetch address
busy  output  1  high in RUN
done  output  1  high in DONE
cycles  output  CW  clock cycles spent in current/last run
ras_ovf  output  1  sticky: push attempted with stack full
ras_unf  output  1  sticky: pop attempted with stack empty

Behaviour:
- Reset (reset==0, async): state IDLE, prog_ctr=START_ADDR, busy=0, done=0, cycles=0, stack empty, ras_ovf=ras_unf=0. Reset mid-run aborts immediately; no state is retained.
- All outputs are registered. busy and done decode directly from state registers.
- States: IDLE, RUN, DONE.
- IDLE:
  - req=1 -> RUN next edge.
  - On that edge: prog_ctr=START_ADDR, cycles=0, stack emptied, ras_ovf/ras_unf cleared.
- RUN, evaluated each edge, first matching rule wins:
  1. halt=1, or prog_ctr==HALT_ADDR: -> DONE. prog_ctr holds. cycles counts this edge. halt takes effect even with stall=1.
  2. stall=1: prog_ctr, stack and flags hold; cycles increments; call/ret/jb_en ignored.
  3. ret=1:
     - Stack non-empty: prog_ctr=top entry, pop.
     - Stack empty: ras_unf<=1, prog_ctr=prog_ctr+1.
  4. call=1:
     - Stack not full: push prog_ctr+1, prog_ctr=target.
     - Stack full: ras_ovf<=1, no push, prog_ctr=target still.
  5. jb_en=1: prog_ctr=target.
  6. Otherwise: prog_ctr=prog_ctr+1.
- Increments wrap modulo 2^D (all-ones -> 0). Pushed return addresses also wrap.
- req is ignored in RUN.
- cycles increments on every RUN edge, including the edge that enters DONE. It saturates at 2^CW-1 and never wraps.
- DONE:
  - done=1; prog_ctr, cycles and flags hold.
  - req=1 -> RUN with the same initialisation as from IDLE. done falls on that edge.
  - req=0 -> stay in DONE.
- Stack is LIFO with RAS_DEPTH entries. Count ranges 0..RAS_DEPTH.
- Simultaneous call and ret: ret wins (rule order above). jb_en together with call: call wins.

Test Plan:
- Straight run: reset; req=1 for 1 cycle; no redirects -> prog_ctr 0,1,...,285; done=1 on the edge after prog_ctr==285; prog_ctr holds 285; cycles=286; busy=0.
- Stall/halt: run; stall=1 for 3 cycles at prog_ctr=10 -> prog_ctr holds 10 for 3 cycles, cycles still advances. halt=1 at prog_ctr=20 with stall=1 -> DONE; prog_ctr=20.
- Call/return: call with target=100 at prog_ctr=5 -> prog_ctr=100. Then call with target=200 at prog_ctr=102 -> prog_ctr=200. ret twice -> prog_ctr=103, then 6. ras_ovf=ras_unf=0.
- Stack boundaries (RAS_DEPTH=4): 5 nested calls -> ras_ovf=1 after the 5th; prog_ctr=5th target. 5 rets -> first 4 return LIFO addresses; the 5th sets ras_unf=1 and increments prog_ctr.
- Wrap/saturate (D=4, HALT_ADDR=3, CW=3): jb_en with target=14 -> prog_ctr 14, 15, 0, 1, 2, 3; done set; cycles saturates at 7.
- Async reset mid-run and restart: pull reset=0 at prog_ctr=50 -> all outputs reset immediately with no clock edge. Restart from DONE via req=1 -> done falls next edge, prog_ctr=START_ADDR, cycles=0.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: req/done handshake, stall, jump/branch redirect,
// call/return address stack and a saturating run-cycle counter.
module prog_sequencer #(
  parameter int D          = 12,
  parameter int START_ADDR = 0,
  parameter int HALT_ADDR  = 285,
  parameter int RAS_DEPTH  = 4,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          jb_en,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycles,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam int CNTW = $clog2(RAS_DEPTH + 1);
  localparam int IDXW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNTW-1:0] L_FULL  = CNTW'(RAS_DEPTH);
  localparam logic [D-1:0]    L_START = D'(START_ADDR);
  localparam logic [D-1:0]    L_HALT  = D'(HALT_ADDR);
  localparam logic [CW-1:0]   L_CMAX  = '1;

  logic [1:0]      r_state;
  logic [D-1:0]    r_pc;
  logic [CW-1:0]   r_cyc;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovf;
  logic            r_unf;
  logic [D-1:0]    r_ras [RAS_DEPTH];

  logic [D-1:0]    w_pc_inc;
  logic [IDXW-1:0] w_push_idx;
  logic [IDXW-1:0] w_pop_idx;
  logic            w_empty;
  logic            w_full;
  logic            w_end;

  assign w_pc_inc   = r_pc + D'(1);
  assign w_push_idx = IDXW'(r_cnt);
  assign w_pop_idx  = IDXW'(r_cnt - CNTW'(1));
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == L_FULL);
  assign w_end      = halt || (r_pc == L_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= L_START;
      r_cyc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (r_cyc != L_CMAX) r_cyc <= r_cyc + CW'(1);
          // halt outranks stall so a frozen core can still be stopped
          if (w_end) begin
            r_state <= S_DONE;
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (ret) begin
            if (w_empty) begin
              r_unf <= 1'b1;
              r_pc  <= w_pc_inc;
            end else begin
              r_pc  <= r_ras[w_pop_idx];
              r_cnt <= r_cnt - CNTW'(1);
            end
          end else if (call) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_ras[w_push_idx] <= w_pc_inc;
              r_cnt             <= r_cnt + CNTW'(1);
            end
            r_pc <= target;
          end else if (jb_en) begin
            r_pc <= target;
          end else begin
            r_pc <= w_pc_inc;
          end
        end
        default: begin
          if (req) begin
            r_state <= S_RUN;
            r_pc    <= L_START;
            r_cyc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign prog_ctr = r_pc;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign cycles   = r_cyc;
  assign ras_ovf  = r_ovf;
  assign ras_unf  = r_unf;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios plus random redirects
// against a queue-based model; a small instance covers wrap/saturation.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, stall, jb_en, call, ret, halt;
  logic [11:0] target;
  logic [11:0] pc;
  logic        busy, done, ovf, unf;
  logic [15:0] cyc;

  logic       s_req, s_jb;
  logic [3:0] s_tgt;
  logic [3:0] s_pc;
  logic       s_busy, s_done, s_ovf, s_unf;
  logic [2:0] s_cyc;

  int checks = 0;
  int errs   = 0;

  int m_st;
  int m_pc;
  int m_cyc;
  int m_ovf;
  int m_unf;
  int m_stk[$];

  always #5 clk = ~clk;

  prog_sequencer u_dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .jb_en(jb_en), .call(call), .ret(ret), .halt(halt),
    .target(target), .prog_ctr(pc), .busy(busy), .done(done),
    .cycles(cyc), .ras_ovf(ovf), .ras_unf(unf)
  );

  prog_sequencer #(.D(4), .START_ADDR(0), .HALT_ADDR(3),
                   .RAS_DEPTH(4), .CW(3)) u_small (
    .clk(clk), .reset(reset), .req(s_req), .stall(1'b0),
    .jb_en(s_jb), .call(1'b0), .ret(1'b0), .halt(1'b0),
    .target(s_tgt), .prog_ctr(s_pc), .busy(s_busy), .done(s_done),
    .cycles(s_cyc), .ras_ovf(s_ovf), .ras_unf(s_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cyc = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  // 0 idle, 1 run, 2 done
  task automatic model_step();
    if (m_st != 1) begin
      if (req) begin
        m_st = 1; m_pc = 0; m_cyc = 0; m_ovf = 0; m_unf = 0;
        m_stk.delete();
      end
    end else begin
      if (m_cyc < 65535) m_cyc++;
      if (halt || m_pc == 285) m_st = 2;
      else if (stall) begin end
      else if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_unf = 1; m_pc = (m_pc + 1) % 4096; end
      end else if (call) begin
        if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 4096);
        else m_ovf = 1;
        m_pc = int'(target);
      end else if (jb_en) m_pc = int'(target);
      else m_pc = (m_pc + 1) % 4096;
    end
  endtask

  task automatic chk_all();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_st == 2));
    chk("cycles", 32'(cyc), 32'(m_cyc));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unf", 32'(unf), 32'(m_unf));
  endtask

  task automatic idle_in();
    req = 0; stall = 0; jb_en = 0; call = 0; ret = 0; halt = 0;
    target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  task automatic run_to(input int a);
    int n = 0;
    idle_in();
    while (m_pc != a && n < 600) begin
      tick();
      n++;
    end
    chk("reach", 32'(pc), 32'(a));
  endtask

  task automatic start();
    idle_in(); req = 1; tick(); req = 0;
  endtask

  initial begin
    int exp_pc;
    idle_in();
    s_req = 0; s_jb = 0; s_tgt = '0;
    reset = 0;
    model_reset();
    #12;
    chk_all();
    chk("s_rst_pc", 32'(s_pc), 0);
    reset = 1;

    // straight run to halt address
    start();
    run_to(285);
    tick();
    chk("straight_done", 32'(done), 1);
    chk("straight_pc", 32'(pc), 285);
    chk("straight_cyc", 32'(cyc), 286);
    tick();
    chk("done_hold_pc", 32'(pc), 285);

    // stall and halt-with-stall
    start();
    chk("restart_done", 32'(done), 0);
    chk("restart_cyc", 32'(cyc), 0);
    run_to(10);
    stall = 1;
    repeat (3) tick();
    chk("stall_pc", 32'(pc), 10);
    run_to(20);
    stall = 1; halt = 1; tick(); idle_in();
    chk("halt_pc", 32'(pc), 20);
    chk("halt_done", 32'(done), 1);

    // nested call / return
    start();
    run_to(5);
    call = 1; target = 100; tick(); idle_in();
    run_to(102);
    call = 1; target = 200; tick(); idle_in();
    chk("call2_pc", 32'(pc), 200);
    ret = 1; tick();
    chk("ret1_pc", 32'(pc), 103);
    tick(); idle_in();
    chk("ret2_pc", 32'(pc), 6);
    halt = 1; tick(); idle_in();

    // stack overflow / underflow
    start();
    for (int i = 0; i < 5; i++) begin
      call = 1; target = 12'(1000 + 8 * i); tick();
    end
    idle_in();
    chk("ovf_pc", 32'(pc), 1032);
    chk("ovf_flag", 32'(ovf), 1);
    ret = 1;
    repeat (5) tick();
    idle_in();
    chk("unf_flag", 32'(unf), 1);
    chk("unf_pc", 32'(pc), 2);
    halt = 1; tick(); idle_in();

    // PC wrap at full width
    start();
    jb_en = 1; target = 12'd4094; tick(); idle_in();
    tick(); tick();
    chk("wrap_pc", 32'(pc), 0);
    halt = 1; tick(); idle_in();

    // async reset mid-run
    start();
    run_to(50);
    #2 reset = 0;
    #1;
    model_reset();
    chk_all();
    reset = 1;
    tick();

    // small instance: wrap and saturation
    s_req = 1; tick(); s_req = 0;
    chk("s_start_pc", 32'(s_pc), 0);
    chk("s_busy", 32'(s_busy), 1);
    s_jb = 1; s_tgt = 4'd14; tick(); s_jb = 0;
    chk("s_jb_pc", 32'(s_pc), 14);
    exp_pc = 14;
    for (int k = 2; k <= 6; k++) begin
      tick();
      exp_pc = (exp_pc + 1) % 16;
      chk("s_wrap_pc", 32'(s_pc), 32'(exp_pc));
      chk("s_wrap_cyc", 32'(s_cyc), 32'(k));
    end
    tick();
    chk("s_done", 32'(s_done), 1);
    chk("s_done_pc", 32'(s_pc), 3);
    chk("s_done_cyc", 32'(s_cyc), 7);
    s_req = 1; tick(); s_req = 0;
    chk("s_restart_cyc", 32'(s_cyc), 0);
    chk("s_restart_done", 32'(s_done), 0);
    s_jb = 1; s_tgt = 4'd4; tick(); s_jb = 0;
    exp_pc = 4;
    for (int k = 2; k <= 16; k++) begin
      tick();
      exp_pc = (exp_pc + 1) % 16;
      chk("s_sat_pc", 32'(s_pc), 32'(exp_pc));
      chk("s_sat_cyc", 32'(s_cyc), 32'(k > 7 ? 7 : k));
    end
    tick();
    chk("s_sat_done", 32'(s_done), 1);
    chk("s_sat_final", 32'(s_cyc), 7);

    // random redirects against the model
    for (int n = 0; n < 500; n++) begin
      req    = ($urandom_range(0, 3) == 0);
      stall  = ($urandom_range(0, 7) == 0);
      halt   = ($urandom_range(0, 63) == 0);
      ret    = ($urandom_range(0, 5) == 0);
      call   = ($urandom_range(0, 5) == 0);
      jb_en  = ($urandom_range(0, 7) == 0);
      target = 12'($urandom_range(0, 4095));
      tick();
    end
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
